// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-4 butterfly datapath.
package fft_pkg;

    // Sequencer states: load four samples, two add/sub stages of two cycles, stream out.
    typedef enum logic [2:0] {
        LOAD = 3'd0,
        S1A  = 3'd1,
        S1B  = 3'd2,
        S2A  = 3'd3,
        S2B  = 3'd4,
        OUT  = 3'd5
    } bfly_state_t;

    localparam int          FP_SIGN_BIT  = 31;
    localparam logic [31:0] FP_SIGN_MASK = 32'h8000_0000;
    localparam logic [31:0] FP_ONE       = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO      = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN      = 32'h7FC0_0000;

    // Complex IEEE-754 single sample; re occupies the upper 32 bits.
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

endpackage

// File: rtl/radix4_bfly_sequencer_if.sv
// Sample stream bundle between the reorder buffer, the sequencer and the twiddle stage.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds valid and data stable until that edge; a sink
// may raise or drop ready at any time, and ready alone never moves data.
interface radix4_bfly_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_real;
    logic [31:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_real;
    logic [31:0] out_im;
    logic        out_last;

    // Environment side: feeds samples in, consumes results.
    modport master (
        output in_valid, in_real, in_im, out_ready,
        input  in_ready, out_valid, out_real, out_im, out_last
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_real, in_im, out_ready,
        output in_ready, out_valid, out_real, out_im, out_last
    );
endinterface

// File: rtl/bfly_rot_j.sv
// Multiply a complex sample by -j (forward) or +j (inverse): swap parts, flip one sign.
module bfly_rot_j
    import fft_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  cplx_t t,
    output cplx_t r
);
    // (a + bj)(-j) = b - aj ; (a + bj)(+j) = -b + aj
    always_comb begin
        r = t;
        if (INVERSE) begin
            r.re = t.im ^ FP_SIGN_MASK;
            r.im = t.re;
        end else begin
            r.re = t.im;
            r.im = t.re ^ FP_SIGN_MASK;
        end
    end
endmodule

// File: rtl/complexAdder.sv
// Complex sum y = a + b, one real adder per component.
module complexAdder
    import fft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    output cplx_t y
);
    logic [31:0] y_re, y_im;

    fp32_add u_re (.a(a.re), .b(b.re), .sub(1'b0), .y(y_re));
    fp32_add u_im (.a(a.im), .b(b.im), .sub(1'b0), .y(y_im));

    assign y = '{re: y_re, im: y_im};
endmodule

// File: rtl/complexSubtracter.sv
// Complex difference y = a - b, one real subtracter per component.
module complexSubtracter
    import fft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    output cplx_t y
);
    logic [31:0] y_re, y_im;

    fp32_add u_re (.a(a.re), .b(b.re), .sub(1'b1), .y(y_re));
    fp32_add u_im (.a(a.im), .b(b.im), .sub(1'b1), .y(y_im));

    assign y = '{re: y_re, im: y_im};
endmodule

// File: rtl/fp32_add.sv
// Combinational IEEE-754 single adder/subtracter, round to nearest even.
module fp32_add
    import fft_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] y
);
    logic        sa, sb, swap, sl, ss, eff_sub, sticky, inc;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ea, eb, el, es, d;
    logic [23:0] ma, mb, ml, ms;
    logic [26:0] ext_s, sh_s, mask, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_n;
    logic [24:0] rnd;

    // Align, add/subtract magnitudes, normalise, round, then patch special operands.
    always_comb begin
        sa    = a[31];
        sb    = b[31] ^ sub;
        ea    = a[30:23];
        eb    = b[30:23];
        ma    = {|ea, a[22:0]};
        mb    = {|eb, b[22:0]};
        swap  = b[30:0] > a[30:0];
        sl    = swap ? sb : sa;
        ss    = swap ? sa : sb;
        el    = swap ? eb : ea;
        es    = swap ? ea : eb;
        ml    = swap ? mb : ma;
        ms    = swap ? ma : mb;
        // denormals sit at an effective exponent of 1 without the hidden bit
        d     = (el == 8'd0 ? 8'd1 : el) - (es == 8'd0 ? 8'd1 : es);
        ext_s = {ms, 3'b000};
        mask  = '0;
        if (d >= 8'd27) begin
            sh_s   = '0;
            sticky = |ext_s;
        end else begin
            mask   = (27'd1 << d) - 27'd1;
            sh_s   = ext_s >> d;
            sticky = |(ext_s & mask);
        end
        sh_s[0] = sh_s[0] | sticky;
        eff_sub = sl ^ ss;
        sum     = eff_sub ? ({1'b0, ml, 3'b000} - {1'b0, sh_s})
                          : ({1'b0, ml, 3'b000} + {1'b0, sh_s});
        exp_n   = {2'b00, (el == 8'd0 ? 8'd1 : el)};
        lz      = '0;
        norm    = sum[26:0];
        if (sum[27]) begin
            norm  = sum[27:1] | {26'd0, sum[0]};
            exp_n = exp_n + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (sum[i]) lz = 5'(26 - i);
            end
            // never shift below the smallest exponent; the result goes denormal instead
            if ({5'd0, lz} >= exp_n) lz = 5'(exp_n - 10'd1);
            norm  = sum[26:0] << lz;
            exp_n = exp_n - {5'd0, lz};
        end
        inc = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd = {1'b0, norm[26:3]} + {24'd0, inc};
        if (rnd[24]) begin
            rnd   = rnd >> 1;
            exp_n = exp_n + 10'd1;
        end
        a_nan = (&ea) & (|a[22:0]);
        b_nan = (&eb) & (|b[22:0]);
        a_inf = (&ea) & ~(|a[22:0]);
        b_inf = (&eb) & ~(|b[22:0]);
        if (a_nan || b_nan || (a_inf && b_inf && (sa ^ sb))) y = FP_QNAN;
        else if (a_inf)                                    y = {sa, 8'hFF, 23'd0};
        else if (b_inf)                                    y = {sb, 8'hFF, 23'd0};
        else if (sum == 28'd0)                             y = {sa & sb, 31'd0};
        else if (exp_n >= 10'd255)                         y = {sl, 8'hFF, 23'd0};
        else y = {sl, (rnd[23] ? exp_n[7:0] : 8'd0), rnd[22:0]};
    end
endmodule

// File: rtl/radix4_bfly_sequencer.sv
// Radix-4 butterfly sequenced through one shared complex adder/subtracter pair.
//
// Register slots are reused in place: x0..x3 hold the inputs, then
// t0->x0, t1->x2, t2->x1, t3->x3, then y0->x0, y2->x1, y1->x2, y3->x3.
// So output k lives in slot bitrev(k).
module radix4_bfly_sequencer
    import fft_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    radix4_bfly_sequencer_if.slave        bus,
    output logic                          busy,
    output bfly_state_t                   fsm_state
);
    bfly_state_t state, state_nxt;
    logic [1:0]  cnt, ocnt;
    logic [1:0]  ia, ib, oidx;
    logic        in_fire, out_fire, do_compute;
    cplx_t       x [4];
    cplx_t       op_a, op_b, t3_rot, add_y, sub_y;

    assign in_fire   = bus.in_valid & bus.in_ready;
    assign out_fire  = bus.out_valid & bus.out_ready;
    assign busy      = !(state == LOAD && cnt == 2'd0);
    assign fsm_state = state;
    assign oidx      = {ocnt[0], ocnt[1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next state and stream handshake outputs.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && cnt == 2'd3) state_nxt = S1A;
            end
            S1A: state_nxt = S1B;
            S1B: state_nxt = S2A;
            S2A: state_nxt = S2B;
            S2B: state_nxt = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && ocnt == 2'd3) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Input and output sample counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 2'd0;
            ocnt <= 2'd0;
        end else begin
            if (in_fire)  cnt  <= cnt + 2'd1;
            if (out_fire) ocnt <= ocnt + 2'd1;
        end
    end

    // Operand slot selection; results return to the same slots they were read from.
    always_comb begin
        ia         = 2'd0;
        ib         = 2'd2;
        do_compute = 1'b1;
        case (state)
            S1A:     begin ia = 2'd0; ib = 2'd2; end
            S1B:     begin ia = 2'd1; ib = 2'd3; end
            S2A:     begin ia = 2'd0; ib = 2'd1; end
            S2B:     begin ia = 2'd2; ib = 2'd3; end
            default: do_compute = 1'b0;
        endcase
        op_a = x[ia];
        op_b = (state == S2B) ? t3_rot : x[ib];
    end

    bfly_rot_j #(.INVERSE(INVERSE)) u_rot (.t(x[3]), .r(t3_rot));

    complexAdder      u_add (.a(op_a), .b(op_b), .y(add_y));
    complexSubtracter u_sub (.a(op_a), .b(op_b), .y(sub_y));

    // Sample store: filled during LOAD, overwritten in place by each compute stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) x[i] <= '0;
        end else if (in_fire) begin
            x[cnt] <= '{re: bus.in_real, im: bus.in_im};
        end else if (do_compute) begin
            x[ia] <= add_y;
            x[ib] <= sub_y;
        end
    end

    // Output data is zero outside OUT and otherwise follows ocnt, so it holds during stalls.
    always_comb begin
        bus.out_real = FP_ZERO;
        bus.out_im   = FP_ZERO;
        bus.out_last = 1'b0;
        if (state == OUT) begin
            bus.out_real = x[oidx].re;
            bus.out_im   = x[oidx].im;
            bus.out_last = (ocnt == 2'd3);
        end
    end
endmodule

// File: tb/tb_radix4_bfly_sequencer.sv
// Directed bench for radix4_bfly_sequencer: forward and inverse instances run in lockstep.
module tb_radix4_bfly_sequencer;
    import fft_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic        in_valid  = 1'b0;
    logic [31:0] in_real   = '0;
    logic [31:0] in_im     = '0;
    logic        out_ready = 1'b0;
    logic        fwd_busy, inv_busy;
    bfly_state_t fwd_state, inv_state;

    radix4_bfly_sequencer_if fwd_if ();
    radix4_bfly_sequencer_if inv_if ();

    assign fwd_if.in_valid  = in_valid;
    assign fwd_if.in_real   = in_real;
    assign fwd_if.in_im     = in_im;
    assign fwd_if.out_ready = out_ready;
    assign inv_if.in_valid  = in_valid;
    assign inv_if.in_real   = in_real;
    assign inv_if.in_im     = in_im;
    assign inv_if.out_ready = out_ready;

    radix4_bfly_sequencer #(.INVERSE(1'b0)) dut_fwd (
        .clk(clk), .rst(rst), .bus(fwd_if.slave), .busy(fwd_busy), .fsm_state(fwd_state)
    );
    radix4_bfly_sequencer #(.INVERSE(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .bus(inv_if.slave), .busy(inv_busy), .fsm_state(inv_state)
    );

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    int          last_acc_cyc = 0;
    logic [64:0] fwd_q [$];
    logic [64:0] inv_q [$];
    logic [64:0] mon_e;
    logic [31:0] ramp_v [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Expected {last, re, im}: forward ramp 1,2,3,4.
    task automatic exp_ramp();
        fwd_q.push_back({1'b0, 32'h4120_0000, 32'h0000_0000});
        fwd_q.push_back({1'b0, 32'hC000_0000, 32'h4000_0000});
        fwd_q.push_back({1'b0, 32'hC000_0000, 32'h0000_0000});
        fwd_q.push_back({1'b1, 32'hC000_0000, 32'hC000_0000});
        inv_q.push_back({1'b0, 32'h4120_0000, 32'h0000_0000});
        inv_q.push_back({1'b0, 32'hC000_0000, 32'hC000_0000});
        inv_q.push_back({1'b0, 32'hC000_0000, 32'h0000_0000});
        inv_q.push_back({1'b1, 32'hC000_0000, 32'h4000_0000});
    endtask

    // Impulse: every output is 1 + 0j (only +0 arises from these zero sums).
    task automatic exp_impulse();
        for (int j = 0; j < 4; j++) begin
            fwd_q.push_back({(j == 3), FP_ONE, FP_ZERO});
            inv_q.push_back({(j == 3), FP_ONE, FP_ZERO});
        end
    endtask

    // Output monitor: every output handshake pops one expected entry per DUT.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && fwd_if.in_ready) last_acc_cyc = cyc;
            if (fwd_if.out_valid) check("in_ready_during_out", fwd_if.in_ready, 0);
            if (fwd_if.out_valid && out_ready) begin
                if (fwd_q.size() == 0) check("fwd_extra_output", 1, 0);
                else begin
                    mon_e = fwd_q.pop_front();
                    check("fwd_y", {fwd_if.out_last, fwd_if.out_real, fwd_if.out_im}, mon_e);
                end
            end
            if (inv_if.out_valid && out_ready) begin
                if (inv_q.size() == 0) check("inv_extra_output", 1, 0);
                else begin
                    mon_e = inv_q.pop_front();
                    check("inv_y", {inv_if.out_last, inv_if.out_real, inv_if.out_im}, mon_e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bfly(input bit impulse, input int max_gap);
        logic [31:0] v;
        int          wait_n;
        for (int j = 0; j < 4; j++) begin
            v = impulse ? ((j == 0) ? FP_ONE : FP_ZERO) : ramp_v[j];
            repeat ($urandom_range(max_gap, 0)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_real  = v;
            in_im    = FP_ZERO;
            wait_n   = 0;
            while (!fwd_if.in_ready && wait_n < 40) begin
                @(posedge clk); #1;
                wait_n++;
            end
            if (wait_n >= 40) check("send_timeout", 1, 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // Four compute cycles after the x3 accept; optionally offer junk that must be ignored.
    task automatic check_compute(input bit junk);
        if (junk) begin
            in_valid = 1'b1;
            in_real  = 32'hDEAD_BEEF;
            in_im    = 32'h1234_5678;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("in_ready_compute", fwd_if.in_ready, 0);
            check("inv_in_ready_compute", inv_if.in_ready, 0);
            check("out_valid_compute", fwd_if.out_valid, 0);
            check("busy_compute", fwd_busy, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_first_out();
        @(negedge clk);
        check("out_valid_rise", fwd_if.out_valid, 1);
        check("out_latency", cyc - last_acc_cyc, 5);
    endtask

    task automatic drain();
        int n = 0;
        while ((fwd_q.size() != 0 || inv_q.size() != 0) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_left", fwd_q.size() + inv_q.size(), 0);
        @(negedge clk);
        check("idle_in_ready", fwd_if.in_ready, 1);
        check("idle_busy", fwd_busy, 0);
    endtask

    task automatic pulse_reset_check(input string tag);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_out_valid"}, fwd_if.out_valid, 0);
        check({tag, "_in_ready"}, fwd_if.in_ready, 1);
        check({tag, "_busy"}, fwd_busy, 0);
        check({tag, "_inv_busy"}, inv_busy, 0);
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", fwd_state, LOAD);
        check("rst_in_ready", fwd_if.in_ready, 1);
        check("rst_out_valid", fwd_if.out_valid, 0);
        check("rst_out_last", fwd_if.out_last, 0);
        check("rst_busy", fwd_busy, 0);
        check("rst_out_data", {fwd_if.out_real, fwd_if.out_im}, 64'd0);
        check("rst_inv_data", {inv_if.out_real, inv_if.out_im, inv_if.out_last}, 65'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ramp, out_ready high in advance; latency and return to LOAD at k+9.
        out_ready = 1'b1;
        exp_ramp();
        send_bfly(1'b0, 0);
        check_compute(1'b0);
        check_first_out();
        repeat (4) @(negedge clk);
        check("ready_again_k9", fwd_if.in_ready, 1);
        check("ready_again_cyc", cyc - last_acc_cyc, 9);
        check("ramp_left", fwd_q.size() + inv_q.size(), 0);

        // Impulse with random input gaps.
        exp_impulse();
        send_bfly(1'b1, 2);
        check_compute(1'b0);
        check_first_out();
        drain();

        // Backpressure: gaps, junk offered during compute, y1 stalled three cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_ramp();
        send_bfly(1'b0, 3);
        check_compute(1'b1);
        @(negedge clk);
        check("stall_y0_valid", fwd_if.out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_y1_fwd", {fwd_if.out_valid, fwd_if.out_last, fwd_if.out_real, fwd_if.out_im},
                  {2'b10, 32'hC000_0000, 32'h4000_0000});
            check("stall_y1_inv", {inv_if.out_real, inv_if.out_im}, {32'hC000_0000, 32'hC000_0000});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Reset in S2A discards the butterfly.
        send_bfly(1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("state_s2a", fwd_state, S2A);
        rst = 1'b1;
        pulse_reset_check("rst_s2a");

        // Reset in OUT discards the remaining outputs.
        out_ready = 1'b0;
        send_bfly(1'b0, 0);
        check_compute(1'b0);
        check_first_out();
        rst = 1'b1;
        pulse_reset_check("rst_out");

        // Ramp after the resets gives the normal results.
        @(posedge clk); #1;
        out_ready = 1'b1;
        exp_ramp();
        send_bfly(1'b0, 1);
        check_compute(1'b0);
        check_first_out();
        drain();

        // Three back-to-back butterflies.
        exp_ramp();
        exp_impulse();
        exp_ramp();
        send_bfly(1'b0, 0);
        check_compute(1'b0);
        send_bfly(1'b1, 0);
        check_compute(1'b0);
        send_bfly(1'b0, 0);
        check_compute(1'b0);
        drain();

        check("final_fwd_q", fwd_q.size(), 0);
        check("final_inv_q", inv_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
